edge_detector_multi: RTL and testbench
======================================

# edge_detector_multi

Multi-channel, parametrised edge detector with input synchronisation, glitch filtering, per-channel edge-mode selection and sticky event capture with overflow. It sits between asynchronous external or cross-domain level inputs (buttons, status lines, interrupt wires) and the register/interrupt logic. It delivers clean single-cycle edge pulses, filtered levels, latched events and a combined interrupt, all in the `clk` domain.

## Interface
- `N_CH`, default 8: number of independent channels, ≥1.
- `SYNC_STAGES`, default 2: synchroniser flops per channel, ≥2.
- `FILT_CYC`, default 4: consecutive stable cycles required before the filtered level changes, ≥1; counter width is clog2(FILT_CYC+1).

Ports (reset is asynchronous, active-high; clock is `clk`):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `a_i` in N_CH: raw asynchronous level inputs.
- `mode_i` in 2*N_CH: per-channel capture mode, bits [2i+1:2i]. 00 off, 01 rise, 10 fall, 11 both.
- `clr_i` in N_CH: per-channel clear of `evt_o`/`ovf_o`, level-sampled each cycle.
- `lvl_o` out N_CH: filtered level.
- `rise_o` out N_CH: one-cycle pulse on a filtered 0→1 transition.
- `fall_o` out N_CH: one-cycle pulse on a filtered 1→0 transition.
- `evt_o` out N_CH: sticky event flag.
- `ovf_o` out N_CH: sticky overflow flag (event lost).
- `irq_o` out 1: OR of all `evt_o` bits.

## Operation
- Synchroniser: `a_i[i]` passes through SYNC_STAGES flops. The last stage is `s[i]`.
- Filter, per channel, uses filtered state `f` (= `lvl_o`) and counter `cnt`:
  - if s==f: cnt←0.
  - else if cnt==FILT_CYC-1: f←s, cnt←0.
  - else: cnt←cnt+1.
  - A single-cycle mismatch resets progress. Only FILT_CYC consecutive mismatching cycles change f.
- Edge pulses are registered and assert in the same cycle the new f becomes visible:
  - rise_o←(update & s==1).
  - fall_o←(update & s==0).
  - Pulses are never wider than 1 cycle.
  - Pulses are independent of `mode_i`.
- Capture: cap[i] = (rise_o[i] & mode[0]) | (fall_o[i] & mode[1]).
  - evt_o: if cap → 1; else if clr_i → 0; else hold. Set beats simultaneous clear.
  - ovf_o: if cap & evt_o & ~clr_i → 1; else if clr_i → 0; else hold.
  - cap with clr_i in the same cycle sets evt_o and does not set ovf_o.
- `mode_i` changes take effect on the next pulse. They never modify existing evt_o/ovf_o and never affect filtering.
- `irq_o` is combinational OR of evt_o flops, with no extra latency.

## Timing
- Reset values: all sync flops, f, cnt, rise_o, fall_o, evt_o, ovf_o = 0, and irq_o = 0.
- A channel held high through reset is seen as a 0→1 transition after release. It produces rise_o at nominal latency.
- Latency: if `a_i` changes and is held before capture edge k, then lvl_o and rise_o/fall_o change after edge k+SYNC_STAGES+FILT_CYC-1. With defaults that is 5 edges.
- evt_o/ovf_o update at the edge after the rise_o/fall_o pulse cycle, i.e. 1 cycle after the pulse.
- The clr_i effect is visible after the next edge.
- Minimum spacing of consecutive opposite edges on one channel is FILT_CYC cycles.
- Reset asserted mid-filter or mid-pulse clears all state immediately. No pulse or event is produced from pre-reset history.
- Channels are fully independent. Simultaneous events on all channels are all captured in the same cycle.

## Test plan
- Defaults, ch0 mode 01, `a_i[0]` 0→1 held before edge 0 -> lvl_o[0]=1 and rise_o[0]=1 for exactly one cycle after edge 5; evt_o[0]=1 and irq_o=1 after edge 6; fall_o stays 0.
- Glitch: `a_i[1]` high for 3 cycles (< FILT_CYC after sync), then low -> no rise_o/fall_o, lvl_o[1] stays 0. A 4-cycle high pulse produces rise_o and then fall_o, spaced 4 cycles apart.
- Mode gating: ch2 mode 10, full 0→1→0 cycle -> rise_o and fall_o both pulse; evt_o[2] sets only after the fall pulse. With mode 00, evt_o never sets.
- Sticky/overflow: two captured edges on ch3 without a clear -> ovf_o[3]=1. clr_i[3] for 1 cycle -> evt_o and ovf_o both 0. clr_i coincident with a capture -> evt_o=1, ovf_o=0.
- Reset: assert reset while `a_i` all 1s and a filter is mid-count -> all outputs 0 immediately. After release with inputs still high, every channel gives rise_o at edge SYNC_STAGES+FILT_CYC-1 after release.
- All 8 channels toggled on the same edge with mode 11 -> 8 simultaneous rise_o bits, evt_o=8'hFF, single irq_o.

Source files
------------

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: synchroniser, glitch filter, edge pulses, sticky capture and irq.
// All outputs are in the clk domain; reset clears every flop asynchronously.
module edge_detector_multi #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     a_i,
  input  logic [2*N_CH-1:0]   mode_i,
  input  logic [N_CH-1:0]     clr_i,
  output logic [N_CH-1:0]     lvl_o,
  output logic [N_CH-1:0]     rise_o,
  output logic [N_CH-1:0]     fall_o,
  output logic [N_CH-1:0]     evt_o,
  output logic [N_CH-1:0]     ovf_o,
  output logic                irq_o
);

  localparam int unsigned CntW = $clog2(FILT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYC - 1);

  logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_CH-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [N_CH-1:0]                  s;
  logic [N_CH-1:0]                  f_q, f_d;
  logic [N_CH-1:0]                  update;
  logic [N_CH-1:0]                  rise_q, rise_d;
  logic [N_CH-1:0]                  fall_q, fall_d;
  logic [N_CH-1:0]                  evt_q, evt_d;
  logic [N_CH-1:0]                  ovf_q, ovf_d;
  logic [N_CH-1:0]                  mode_rise, mode_fall;
  logic [N_CH-1:0]                  cap;

  // Synchroniser chain: stage 0 samples the raw input, the top stage feeds the filter.
  always_comb begin
    sync_d = sync_q;
    s      = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], a_i[i]};
      s[i]      = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Filter: any agreeing cycle restarts the count, so only an unbroken run of
  // FILT_CYC mismatching samples moves the filtered level.
  always_comb begin
    f_d    = f_q;
    cnt_d  = '0;
    update = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (s[i] != f_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          f_d[i]    = s[i];
          update[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    rise_d = update & s;
    fall_d = update & ~s;
  end

  always_comb begin
    mode_rise = '0;
    mode_fall = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      mode_rise[i] = mode_i[2*i];
      mode_fall[i] = mode_i[2*i+1];
    end
  end

  // A capture wins over a simultaneous clear; an overflow needs an event already pending
  // and is suppressed when the clear lands on the same cycle.
  always_comb begin
    cap   = (rise_q & mode_rise) | (fall_q & mode_fall);
    evt_d = cap | (evt_q & ~clr_i);
    ovf_d = (cap & evt_q & ~clr_i) | (ovf_q & ~clr_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign lvl_o  = f_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign evt_o  = evt_q;
  assign ovf_o  = ovf_q;
  assign irq_o  = |evt_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: directed scenarios plus a randomized run against
// a sample-history reference model.
module tb_edge_detector_multi;

  localparam int unsigned N    = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 4;
  localparam int unsigned LAT  = SYNC + FILT - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   a_i;
  logic [2*N-1:0] mode_i;
  logic [N-1:0]   clr_i;
  logic [N-1:0]   lvl_o, rise_o, fall_o, evt_o, ovf_o;
  logic           irq_o;

  int tests_run    = 0;
  int tests_failed = 0;

  edge_detector_multi #(
    .N_CH        (N),
    .SYNC_STAGES (SYNC),
    .FILT_CYC    (FILT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a_i    (a_i),
    .mode_i (mode_i),
    .clr_i  (clr_i),
    .lvl_o  (lvl_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .evt_o  (evt_o),
    .ovf_o  (ovf_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model: raw input history per channel and the recent synchronised samples.
  bit           ahist [N][$];
  bit           shist [N][$];
  logic [N-1:0] m_lvl, m_rise, m_fall, m_evt, m_ovf;

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      ahist[i].delete();
      repeat (SYNC) ahist[i].push_back(1'b0);
      shist[i].delete();
    end
    m_lvl = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_ovf = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] nr, nf;
    nr = '0;
    nf = '0;
    for (int i = 0; i < int'(N); i++) begin
      bit s, cap, all_diff;
      cap = (m_rise[i] && mode_i[2*i]) || (m_fall[i] && mode_i[2*i+1]);
      if (cap && m_evt[i] && !clr_i[i]) m_ovf[i] = 1'b1;
      else if (clr_i[i])                m_ovf[i] = 1'b0;
      if (cap)           m_evt[i] = 1'b1;
      else if (clr_i[i]) m_evt[i] = 1'b0;
      s = ahist[i].pop_front();
      ahist[i].push_back(a_i[i]);
      shist[i].push_back(s);
      if (shist[i].size() > FILT) void'(shist[i].pop_front());
      all_diff = (shist[i].size() == FILT);
      for (int k = 0; k < shist[i].size(); k++)
        if (shist[i][k] == m_lvl[i]) all_diff = 1'b0;
      if (all_diff) begin
        nr[i]    = s;
        nf[i]    = !s;
        m_lvl[i] = s;
        shist[i].delete();
      end
    end
    m_rise = nr;
    m_fall = nf;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; a_i = '0; mode_i = '0; clr_i = '0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; a_i = '0; mode_i = '0; clr_i = '0;
    model_reset();
    #1;
    tests_run++;
    if ({lvl_o, rise_o, fall_o, evt_o, ovf_o, irq_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: lvl=%h rise=%h fall=%h evt=%h ovf=%h irq=%b, required all 0",
               lvl_o, rise_o, fall_o, evt_o, ovf_o, irq_o);
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_latency();
    logic exp_lvl, exp_rise, exp_evt;
    mode_i = 16'h0001;
    a_i[0] = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      tick();
      exp_lvl  = (j >= 5);
      exp_rise = (j == 5);
      exp_evt  = (j >= 6);
      tests_run++;
      if (lvl_o[0] !== exp_lvl || rise_o[0] !== exp_rise || fall_o[0] !== 1'b0 ||
          evt_o[0] !== exp_evt || irq_o !== exp_evt) begin
        tests_failed++;
        $display("FAIL latency edge %0d: lvl=%b rise=%b fall=%b evt=%b irq=%b, required %b %b 0 %b %b",
                 j, lvl_o[0], rise_o[0], fall_o[0], evt_o[0], irq_o,
                 exp_lvl, exp_rise, exp_evt, exp_evt);
      end
    end
  endtask

  task automatic test_glitch();
    int seen, rise_at, fall_at, n_rise, n_fall;
    seen = 0;
    a_i[1] = 1'b1;
    repeat (3) tick();
    a_i[1] = 1'b0;
    repeat (12) begin
      tick();
      if (rise_o[1] || fall_o[1] || lvl_o[1]) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL glitch_short: %0d active cycles, required 0", seen);
    end
    rise_at = -1; fall_at = -1; n_rise = 0; n_fall = 0;
    a_i[1] = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 3) a_i[1] = 1'b0;
      if (rise_o[1]) begin n_rise++; rise_at = j; end
      if (fall_o[1]) begin n_fall++; fall_at = j; end
    end
    tests_run++;
    if (n_rise !== 1 || n_fall !== 1) begin
      tests_failed++;
      $display("FAIL glitch_4cyc_count: rise=%0d fall=%0d, required 1 1", n_rise, n_fall);
    end
    tests_run++;
    if (rise_at !== int'(LAT) || fall_at - rise_at !== int'(FILT)) begin
      tests_failed++;
      $display("FAIL glitch_4cyc_timing: rise_at=%0d spacing=%0d, required %0d %0d",
               rise_at, fall_at - rise_at, LAT, FILT);
    end
  endtask

  task automatic test_mode_gating();
    int n_rise, n_fall, evt_seen;
    mode_i = 16'h0020;
    n_rise = 0; n_fall = 0;
    a_i[2] = 1'b1;
    repeat (10) begin tick(); if (rise_o[2]) n_rise++; end
    tests_run++;
    if (n_rise !== 1 || evt_o[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL mode10_rise: rises=%0d evt=%b, required 1 0", n_rise, evt_o[2]);
    end
    a_i[2] = 1'b0;
    repeat (10) begin tick(); if (fall_o[2]) n_fall++; end
    tests_run++;
    if (n_fall !== 1 || evt_o[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mode10_fall: falls=%0d evt=%b, required 1 1", n_fall, evt_o[2]);
    end
    mode_i = '0;
    clr_i[2] = 1'b1;
    tick();
    clr_i[2] = 1'b0;
    n_rise = 0; n_fall = 0; evt_seen = 0;
    a_i[2] = 1'b1;
    repeat (10) begin tick(); if (rise_o[2]) n_rise++; if (evt_o[2]) evt_seen++; end
    a_i[2] = 1'b0;
    repeat (10) begin tick(); if (fall_o[2]) n_fall++; if (evt_o[2]) evt_seen++; end
    tests_run++;
    if (n_rise !== 1 || n_fall !== 1 || evt_seen !== 0) begin
      tests_failed++;
      $display("FAIL mode00: rises=%0d falls=%0d evt_cycles=%0d, required 1 1 0",
               n_rise, n_fall, evt_seen);
    end
  endtask

  task automatic test_sticky();
    bit found;
    mode_i = 16'h00C0;
    a_i[3] = 1'b1;
    repeat (10) tick();
    tests_run++;
    if (evt_o[3] !== 1'b1 || ovf_o[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sticky_first: evt=%b ovf=%b, required 1 0", evt_o[3], ovf_o[3]);
    end
    a_i[3] = 1'b0;
    repeat (10) tick();
    tests_run++;
    if (evt_o[3] !== 1'b1 || ovf_o[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sticky_overflow: evt=%b ovf=%b, required 1 1", evt_o[3], ovf_o[3]);
    end
    clr_i[3] = 1'b1;
    tick();
    clr_i[3] = 1'b0;
    tests_run++;
    if (evt_o[3] !== 1'b0 || ovf_o[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sticky_clear: evt=%b ovf=%b, required 0 0", evt_o[3], ovf_o[3]);
    end
    a_i[3] = 1'b1;
    repeat (10) tick();
    a_i[3] = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 20 && !found; j++) begin
      tick();
      if (fall_o[3]) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL sticky_wait_fall: no fall pulse within 20 cycles, required one");
    end else begin
      clr_i[3] = 1'b1;
      tick();
      clr_i[3] = 1'b0;
      tests_run++;
      if (evt_o[3] !== 1'b1 || ovf_o[3] !== 1'b0) begin
        tests_failed++;
        $display("FAIL sticky_clr_with_cap: evt=%b ovf=%b, required 1 0", evt_o[3], ovf_o[3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp_rise, exp_lvl, exp_evt;
    mode_i = 16'hFFFF;
    a_i    = 8'hFF;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if ({lvl_o, rise_o, fall_o, evt_o, ovf_o, irq_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: lvl=%h rise=%h fall=%h evt=%h ovf=%h irq=%b, required all 0",
               lvl_o, rise_o, fall_o, evt_o, ovf_o, irq_o);
    end
    tick();
    reset = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      tick();
      exp_rise = (j == int'(LAT)) ? 8'hFF : 8'h00;
      exp_lvl  = (j >= int'(LAT)) ? 8'hFF : 8'h00;
      exp_evt  = (j > int'(LAT))  ? 8'hFF : 8'h00;
      tests_run++;
      if (rise_o !== exp_rise || lvl_o !== exp_lvl || evt_o !== exp_evt || ovf_o !== 8'h00 ||
          fall_o !== 8'h00 || irq_o !== (|exp_evt)) begin
        tests_failed++;
        $display("FAIL reset_release edge %0d: rise=%h lvl=%h evt=%h ovf=%h fall=%h irq=%b, required %h %h %h 00 00 %b",
                 j, rise_o, lvl_o, evt_o, ovf_o, fall_o, irq_o, exp_rise, exp_lvl, exp_evt, |exp_evt);
      end
    end
  endtask

  task automatic test_all_channels();
    logic [N-1:0] exp_fall, exp_evt;
    clr_i = 8'hFF;
    tick();
    clr_i = 8'h00;
    tests_run++;
    if (evt_o !== 8'h00 || ovf_o !== 8'h00 || irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL all_clear: evt=%h ovf=%h irq=%b, required 00 00 0", evt_o, ovf_o, irq_o);
    end
    a_i = 8'h00;
    for (int j = 0; j <= 6; j++) begin
      tick();
      exp_fall = (j == int'(LAT)) ? 8'hFF : 8'h00;
      exp_evt  = (j > int'(LAT))  ? 8'hFF : 8'h00;
      tests_run++;
      if (fall_o !== exp_fall || evt_o !== exp_evt || ovf_o !== 8'h00 ||
          irq_o !== (|exp_evt)) begin
        tests_failed++;
        $display("FAIL all_channels edge %0d: fall=%h evt=%h ovf=%h irq=%b, required %h %h 00 %b",
                 j, fall_o, evt_o, ovf_o, irq_o, exp_fall, exp_evt, |exp_evt);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++)
        if ($urandom_range(0, 5) == 0) a_i[i] = ~a_i[i];
      if (c % 50 == 0) mode_i = 16'($urandom);
      clr_i = 8'($urandom & $urandom & $urandom);
      if (c == 1500) begin
        #2;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
      end
      tick();
      tests_run++;
      if ({lvl_o, rise_o, fall_o, evt_o, ovf_o, irq_o} !==
          {m_lvl, m_rise, m_fall, m_evt, m_ovf, |m_evt}) begin
        tests_failed++;
        $display("FAIL random cycle %0d: lvl=%h rise=%h fall=%h evt=%h ovf=%h irq=%b, required %h %h %h %h %h %b",
                 c, lvl_o, rise_o, fall_o, evt_o, ovf_o, irq_o,
                 m_lvl, m_rise, m_fall, m_evt, m_ovf, |m_evt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_mode_gating();
    test_sticky();
    test_reset_mid();
    test_all_channels();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
